// File: rtl/alu_gpr_pc_core.sv
// alu_gpr_pc_core
// Execution datapath of the 8-bit processor. It has three parts:
//   - An 8x8-bit general-purpose register file. It has two registered read
//     ports and one write port. A second write can put the MUL high byte
//     into R[(c+1) mod 8].
//   - A combinational 16-function ALU. It produces flags {V,S,C,Z}, and the
//     flags can be latched into the status register sreg.
//   - An 8-bit program counter with jump and hold control.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   reg_a_num/reg_b_num          read indices (latched when read_en is high)
//   reg_c_num/reg_c_in/write_en  write index, write data, write enable
//   mul_high_we                  used with write_en; also writes alu_result[15:8]
//   alu_fsl, flag_en             ALU function select, sreg latch enable
//   jump, jump_line, hold        PC control
//   reg_a_data/reg_b_data        registered read data (ALU operands A/B)
//   alu_result, alu_flags        combinational ALU outputs
//   sreg, pc, pc_next            status register, current PC, next PC
module alu_gpr_pc_core (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  reg_a_num,
    input  logic [2:0]  reg_b_num,
    input  logic [2:0]  reg_c_num,
    input  logic        read_en,
    input  logic        write_en,
    input  logic [7:0]  reg_c_in,
    input  logic        mul_high_we,
    input  logic [3:0]  alu_fsl,
    input  logic        flag_en,
    input  logic        jump,
    input  logic [7:0]  jump_line,
    input  logic        hold,
    output logic [7:0]  reg_a_data,
    output logic [7:0]  reg_b_data,
    output logic [15:0] alu_result,
    output logic [3:0]  alu_flags,
    output logic [3:0]  sreg,
    output logic [7:0]  pc,
    output logic [7:0]  pc_next
);

    localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_MUL = 4'h2, OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4, OP_XOR = 4'h5, OP_NOT = 4'h6, OP_NEG = 4'h7;
    localparam logic [3:0] OP_SHL = 4'h8, OP_SHR = 4'h9, OP_ASR = 4'hA, OP_ROL = 4'hB;
    localparam logic [3:0] OP_ROR = 4'hC, OP_INC = 4'hD, OP_DEC = 4'hE, OP_PSB = 4'hF;

    // ---------------- register file ----------------
    logic [7:0] gpr_q [8];
    logic [2:0] hi_idx;
    logic [7:0] reg_a_data_reg, reg_b_data_reg;

    // The 3-bit add wraps, so c=7 sends the high byte to R0.
    assign hi_idx = reg_c_num + 3'd1;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_gpr
            logic [7:0] val_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    val_reg <= '0;
                end else if (write_en && reg_c_num == 3'(gi)) begin
                    val_reg <= reg_c_in;
                end else if (write_en && mul_high_we && hi_idx == 3'(gi)) begin
                    val_reg <= alu_result[15:8];
                end
            end
            assign gpr_q[gi] = val_reg;
        end
    endgenerate

    // The read ports sample the array before this edge's write takes effect.
    // So a read and a write to the same register on one edge return the old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_a_data_reg <= '0;
            reg_b_data_reg <= '0;
        end else if (read_en) begin
            reg_a_data_reg <= gpr_q[reg_a_num];
            reg_b_data_reg <= gpr_q[reg_b_num];
        end
    end

    assign reg_a_data = reg_a_data_reg;
    assign reg_b_data = reg_b_data_reg;

    // ---------------- ALU ----------------
    logic [7:0]  op_a, op_b;
    logic [8:0]  sum9, diff9;
    logic [15:0] prod;
    logic [15:0] res_c;
    logic        c_c, v_c;

    assign op_a  = reg_a_data_reg;
    assign op_b  = reg_b_data_reg;
    assign sum9  = {1'b0, op_a} + {1'b0, op_b};
    assign diff9 = {1'b0, op_a} - {1'b0, op_b};   // bit 8 is the borrow
    assign prod  = {8'd0, op_a} * {8'd0, op_b};

    always_comb begin
        res_c = '0;
        c_c   = 1'b0;
        v_c   = 1'b0;
        case (alu_fsl)
            OP_ADD: begin
                res_c[7:0] = sum9[7:0];
                c_c        = sum9[8];
                v_c        = (op_a[7] == op_b[7]) && (sum9[7] != op_a[7]);
            end
            OP_SUB: begin
                res_c[7:0] = diff9[7:0];
                c_c        = diff9[8];
                v_c        = (op_a[7] != op_b[7]) && (diff9[7] != op_a[7]);
            end
            OP_MUL: begin
                res_c = prod;
                c_c   = (prod[15:8] != 8'd0);
            end
            OP_AND: res_c[7:0] = op_a & op_b;
            OP_OR:  res_c[7:0] = op_a | op_b;
            OP_XOR: res_c[7:0] = op_a ^ op_b;
            OP_NOT: res_c[7:0] = ~op_a;
            OP_NEG: begin
                res_c[7:0] = 8'd0 - op_a;
                c_c        = (op_a != 8'd0);
                v_c        = (op_a == 8'h80);
            end
            OP_SHL: begin
                res_c[7:0] = {op_a[6:0], 1'b0};
                c_c        = op_a[7];
            end
            OP_SHR: begin
                res_c[7:0] = {1'b0, op_a[7:1]};
                c_c        = op_a[0];
            end
            OP_ASR: begin
                res_c[7:0] = {op_a[7], op_a[7:1]};
                c_c        = op_a[0];
            end
            OP_ROL: begin
                res_c[7:0] = {op_a[6:0], op_a[7]};
                c_c        = op_a[7];
            end
            OP_ROR: begin
                res_c[7:0] = {op_a[0], op_a[7:1]};
                c_c        = op_a[0];
            end
            OP_INC: begin
                res_c[7:0] = op_a + 8'd1;
                c_c        = (op_a == 8'hFF);
                v_c        = (op_a == 8'h7F);
            end
            OP_DEC: begin
                res_c[7:0] = op_a - 8'd1;
                c_c        = (op_a == 8'h00);
                v_c        = (op_a == 8'h80);
            end
            OP_PSB: res_c[7:0] = op_b;
            default: res_c = '0;
        endcase
    end

    assign alu_result = res_c;
    // The high byte is zero for every function except MUL.
    // So a 16-bit zero test is correct for all functions.
    assign alu_flags  = {v_c,
                         (alu_fsl == OP_MUL) ? res_c[15] : res_c[7],
                         c_c,
                         (res_c == 16'd0)};

    logic [3:0] sreg_reg;
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg_reg <= '0;
        end else if (flag_en) begin
            sreg_reg <= alu_flags;
        end
    end
    assign sreg = sreg_reg;

    // ---------------- program counter ----------------
    logic [7:0] pc_reg, pc_next_c;

    assign pc_next_c = jump ? jump_line : (hold ? pc_reg : pc_reg + 8'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg <= '0;
        end else begin
            pc_reg <= pc_next_c;
        end
    end

    assign pc      = pc_reg;
    assign pc_next = pc_next_c;

endmodule

// File: tb/tb_alu_gpr_pc_core.sv
// Bench for alu_gpr_pc_core. The stimulus drives inputs 1 time unit after
// each rising edge. It pushes the expected output values into a scoreboard
// queue. A monitor drains the queue on each falling edge and compares.
module tb_alu_gpr_pc_core;

    logic        clk;
    logic        rst;
    logic [2:0]  reg_a_num, reg_b_num, reg_c_num;
    logic        read_en, write_en, mul_high_we, flag_en, jump, hold;
    logic [7:0]  reg_c_in, jump_line;
    logic [3:0]  alu_fsl;
    logic [7:0]  reg_a_data, reg_b_data, pc, pc_next;
    logic [15:0] alu_result;
    logic [3:0]  alu_flags, sreg;

    alu_gpr_pc_core dut (
        .clk(clk), .rst(rst),
        .reg_a_num(reg_a_num), .reg_b_num(reg_b_num), .reg_c_num(reg_c_num),
        .read_en(read_en), .write_en(write_en), .reg_c_in(reg_c_in),
        .mul_high_we(mul_high_we), .alu_fsl(alu_fsl), .flag_en(flag_en),
        .jump(jump), .jump_line(jump_line), .hold(hold),
        .reg_a_data(reg_a_data), .reg_b_data(reg_b_data),
        .alu_result(alu_result), .alu_flags(alu_flags), .sreg(sreg),
        .pc(pc), .pc_next(pc_next)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int S_RA = 0, S_RB = 1, S_RES = 2, S_FLG = 3, S_SREG = 4, S_PC = 5, S_PCN = 6;

    typedef struct {
        int          sel;
        logic [15:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Monitor: compares every pending expectation against the settled outputs.
    always @(negedge clk) begin
        while (sb.size() > 0) begin : drain
            exp_t        e;
            logic [15:0] act;
            e = sb.pop_front();
            case (e.sel)
                S_RA:    act = {8'd0, reg_a_data};
                S_RB:    act = {8'd0, reg_b_data};
                S_RES:   act = alu_result;
                S_FLG:   act = {12'd0, alu_flags};
                S_SREG:  act = {12'd0, sreg};
                S_PC:    act = {8'd0, pc};
                default: act = {8'd0, pc_next};
            endcase
            checks++;
            if (act !== e.val) begin
                errors++;
                $display("FAIL %s: got 0x%04h, expected 0x%04h", e.name, act, e.val);
            end else begin
                $display("ok   %s: 0x%04h", e.name, act);
            end
        end
    end

    task automatic expect_out(input int sel, input logic [15:0] val, input string name);
        exp_t e;
        e.sel  = sel;
        e.val  = val;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] c, input logic [7:0] d);
        write_en  = 1'b1;
        reg_c_num = c;
        reg_c_in  = d;
        tick();
        write_en  = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [2:0] b);
        read_en   = 1'b1;
        reg_a_num = a;
        reg_b_num = b;
        tick();
        read_en   = 1'b0;
    endtask

    // Selects an ALU function on the current operands and expects result and flags.
    task automatic alu_chk(input logic [3:0] fsl, input logic [15:0] res,
                           input logic [3:0] flg, input string tag);
        alu_fsl = fsl;
        expect_out(S_RES, res, $sformatf("%s_f%0h_result", tag, fsl));
        expect_out(S_FLG, {12'd0, flg}, $sformatf("%s_f%0h_flags", tag, fsl));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; reg_a_num = 0; reg_b_num = 0; reg_c_num = 0;
        read_en = 0; write_en = 0; mul_high_we = 0; flag_en = 0;
        jump = 0; hold = 1'b1; reg_c_in = 0; jump_line = 0; alu_fsl = 0;
        tick(); tick();
        rst = 1'b0;

        // Put arbitrary state everywhere, then reset it all.
        wr(3'd1, 8'h55);
        wr(3'd6, 8'hAA);
        alu_fsl = 4'h6; flag_en = 1'b1;        // NOT 0x00 = 0xFF -> S only
        tick();
        flag_en = 1'b0;
        expect_out(S_SREG, 16'h0004, "pre_sreg");
        jump = 1'b1; jump_line = 8'h33;
        tick();
        jump = 1'b0;
        expect_out(S_PC, 16'h0033, "pre_jump_pc");
        rd(3'd1, 3'd6);
        expect_out(S_RA, 16'h0055, "pre_read_a");
        expect_out(S_RB, 16'h00AA, "pre_read_b");

        rst = 1'b1; write_en = 1'b1; reg_c_num = 3'd2; reg_c_in = 8'h77;
        read_en = 1'b1; reg_a_num = 3'd1; flag_en = 1'b1; jump = 1'b1;
        tick();
        rst = 1'b0; write_en = 1'b0; read_en = 1'b0; flag_en = 1'b0; jump = 1'b0;
        expect_out(S_RA, 16'h0000, "rst_reg_a");
        expect_out(S_RB, 16'h0000, "rst_reg_b");
        expect_out(S_SREG, 16'h0000, "rst_sreg");
        expect_out(S_PC, 16'h0000, "rst_pc");
        for (int i = 0; i < 8; i += 2) begin
            rd(3'(i), 3'(i + 1));
            expect_out(S_RA, 16'h0000, $sformatf("rst_R%0d", i));
            expect_out(S_RB, 16'h0000, $sformatf("rst_R%0d", i + 1));
        end

        // A=200, B=100: the full function table.
        wr(3'd1, 8'd200);
        wr(3'd2, 8'd100);
        rd(3'd1, 3'd2);
        flag_en = 1'b1;
        alu_chk(4'h0, 16'h002C, 4'b0010, "c8_64");
        flag_en = 1'b0;
        expect_out(S_SREG, 16'h0002, "sreg_after_add");
        alu_chk(4'h1, 16'h0064, 4'b1000, "c8_64");
        alu_chk(4'h2, 16'h4E20, 4'b0010, "c8_64");
        alu_chk(4'h3, 16'h0040, 4'b0000, "c8_64");
        alu_chk(4'h4, 16'h00EC, 4'b0100, "c8_64");
        alu_chk(4'h5, 16'h00AC, 4'b0100, "c8_64");
        alu_chk(4'h6, 16'h0037, 4'b0000, "c8_64");
        alu_chk(4'h7, 16'h0038, 4'b0010, "c8_64");
        alu_chk(4'h8, 16'h0090, 4'b0110, "c8_64");
        alu_chk(4'h9, 16'h0064, 4'b0000, "c8_64");
        alu_chk(4'hA, 16'h00E4, 4'b0100, "c8_64");
        alu_chk(4'hB, 16'h0091, 4'b0110, "c8_64");
        alu_chk(4'hC, 16'h0064, 4'b0000, "c8_64");
        alu_chk(4'hD, 16'h00C9, 4'b0100, "c8_64");
        alu_chk(4'hE, 16'h00C7, 4'b0100, "c8_64");
        alu_chk(4'hF, 16'h0064, 4'b0000, "c8_64");
        expect_out(S_SREG, 16'h0002, "sreg_held");

        // Signed overflow on ADD, then zero on SUB (latched into sreg).
        wr(3'd1, 8'h7F);
        wr(3'd2, 8'h01);
        rd(3'd1, 3'd2);
        alu_chk(4'h0, 16'h0080, 4'b1100, "7f_01");
        wr(3'd1, 8'h05);
        wr(3'd2, 8'h05);
        rd(3'd1, 3'd2);
        flag_en = 1'b1;
        alu_chk(4'h1, 16'h0000, 4'b0001, "05_05");
        flag_en = 1'b0;
        expect_out(S_SREG, 16'h0001, "sreg_zero");

        // Boundaries with A = B = same register.
        wr(3'd1, 8'h80);
        rd(3'd1, 3'd1);
        alu_chk(4'h0, 16'h0000, 4'b1011, "80_80");
        alu_chk(4'h7, 16'h0080, 4'b1110, "80_80");
        alu_chk(4'hE, 16'h007F, 4'b1000, "80_80");
        wr(3'd1, 8'hFF);
        rd(3'd1, 3'd1);
        alu_chk(4'hD, 16'h0000, 4'b0011, "ff_ff");
        alu_chk(4'h2, 16'hFE01, 4'b0110, "ff_ff");
        wr(3'd1, 8'h00);
        rd(3'd1, 3'd1);
        alu_chk(4'hE, 16'h00FF, 4'b0110, "00_00");

        // MUL with high-byte write, c=7 wraps to R0.
        wr(3'd3, 8'h10);
        wr(3'd4, 8'h20);
        rd(3'd3, 3'd4);
        alu_fsl = 4'h2;
        expect_out(S_RES, 16'h0200, "mul_result");
        expect_out(S_FLG, 16'h0002, "mul_flags");
        mul_high_we = 1'b1;
        wr(3'd7, 8'h00);
        mul_high_we = 1'b0;
        rd(3'd7, 3'd0);
        expect_out(S_RA, 16'h0000, "mul_R7");
        expect_out(S_RB, 16'h0002, "mul_R0");

        // A read and a write to the same register on one edge return the old value.
        wr(3'd5, 8'h03);
        write_en = 1'b1; reg_c_num = 3'd5; reg_c_in = 8'h09;
        read_en = 1'b1; reg_a_num = 3'd5; reg_b_num = 3'd5;
        tick();
        write_en = 1'b0; read_en = 1'b0;
        expect_out(S_RA, 16'h0003, "rw_same_old");
        rd(3'd5, 3'd5);
        expect_out(S_RA, 16'h0009, "rw_same_new");

        // PC: reset to 0, free-run through the wrap, then hold and jump.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        hold = 1'b0;
        expect_out(S_PC, 16'h0000, "pc_start");
        expect_out(S_PCN, 16'h0001, "pc_next_start");
        for (int i = 1; i <= 256; i++) begin
            tick();
            expect_out(S_PC, 16'(i % 256), $sformatf("pc_run_%0d", i));
        end
        tick();
        expect_out(S_PC, 16'h0001, "pc_after_wrap");
        hold = 1'b1;
        expect_out(S_PCN, 16'h0001, "pc_next_hold");
        tick(); tick(); tick();
        expect_out(S_PC, 16'h0001, "pc_hold");
        jump = 1'b1; jump_line = 8'h40;
        expect_out(S_PCN, 16'h0040, "pc_next_jump");
        tick();
        jump = 1'b0; hold = 1'b0;
        expect_out(S_PC, 16'h0040, "pc_jump");
        tick();
        expect_out(S_PC, 16'h0041, "pc_after_jump");

        tick(); tick();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_gpr_pc_core.md
Name: alu_gpr_pc_core

Overview:
- Execution datapath core of the 8-bit processor: an 8x8-bit general-purpose register file (two read ports, one write port plus a multiply-high write), a combinational 16-function ALU with 4 status flags and a latched status register (SREG), and an 8-bit program counter with jump/hold control.
- The processor control FSM drives all enables and selects; instruction and data memories sit outside this block.

Parameters:
- None. All widths are fixed: 8-bit data, 3-bit register index, 8-bit PC, 4-bit function select.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  synchronous reset, active-high
- reg_a_num  in  3  read port A register index
- reg_b_num  in  3  read port B register index
- reg_c_num  in  3  write register index
- read_en  in  1  latch both read ports
- write_en  in  1  write reg_c_in into R[reg_c_num]
- reg_c_in  in  8  write data (ALU low byte, immediate, or memory, muxed by control)
- mul_high_we  in  1  with write_en, also write ALU high byte into R[(reg_c_num+1) mod 8]
- alu_fsl  in  4  ALU function select
- flag_en  in  1  latch ALU flags into sreg
- jump  in  1  load PC from jump_line
- jump_line  in  8  branch target
- hold  in  1  freeze PC
- reg_a_data  out  8  registered read data, port A
- reg_b_data  out  8  registered read data, port B
- alu_result  out  16  {high byte, low byte}; high byte is 0 except for MUL
- alu_flags  out  4  combinational flags {V,S,C,Z} = bits [3:0]
- sreg  out  4  latched status register, same bit order
- pc  out  8  current PC
- pc_next  out  8  combinational next PC

Behaviour:
Reset: rst high at a rising edge clears R0..R7, reg_a_data, reg_b_data, sreg and pc to 0. rst has priority over every other input.

Register file:
- Read: if read_en at a rising edge, reg_a_data<=R[a] and reg_b_data<=R[b]; otherwise both hold. Latency is 1 cycle.
- Write: if write_en, R[c]<=reg_c_in. If mul_high_we is also high, R[(c+1) mod 8]<=alu_result[15:8]; c=7 writes the high byte into R0.
- Write and read of the same register in the same edge: the read returns the old value.
- A = B index is legal.

ALU: combinational; operand A = reg_a_data, B = reg_b_data.
- 0 ADD A+B
- 1 SUB A-B
- 2 MUL unsigned A*B, 16-bit
- 3 AND
- 4 OR
- 5 XOR
- 6 NOT A
- 7 NEG A (0-A)
- 8 SHL A
- 9 SHR A (logical)
- A ASR A
- B ROL A
- C ROR A
- D INC A
- E DEC A
- F PASS B

ALU flags:
- Z: result == 0 (for MUL, the full 16 bits).
- C: carry-out for ADD/INC; borrow (A<B unsigned) for SUB/NEG/DEC; high byte != 0 for MUL; bit shifted or rotated out for 8–C; 0 otherwise.
- S: bit 7 of the result (bit 15 for MUL).
- V: two's-complement overflow for ADD/SUB/NEG/INC/DEC; 0 otherwise.
- sreg<=alu_flags when flag_en is high at a rising edge; otherwise sreg holds.

PC:
- pc_next = jump ? jump_line : hold ? pc : pc+1 (mod 256; 255 wraps to 0).
- pc<=pc_next every edge. jump has priority over hold.

Test Plan:
- rst high for 1 edge after arbitrary writes -> all registers, sreg, pc, reg_a_data and reg_b_data read 0.
- Write R1=200, R2=100. read_en with a=1, b=2. fsl=0 -> alu_result=0x002C, C=1, Z=0, V=0, S=0. flag_en -> sreg=4'b0010.
- R1=0x7F, R2=0x01, fsl=0 -> 0x80, V=1, S=1. fsl=1 with R1=R2=5 -> result 0, Z=1.
- R3=0x10, R4=0x20, fsl=2, reg_c_num=7, write_en+mul_high_we, reg_c_in=alu_result[7:0] -> R7=0x00, R0=0x02, C=1.
- Same-edge write R5=9 with read_en a=5 (old value 3) -> reg_a_data=3; next read gives 9.
- pc runs 0..255 -> wraps to 0. hold=1 freezes pc. jump=1 with hold=1, jump_line=0x40 -> pc=0x40 next edge.
